// File: rtl/fd_cmd_if.sv
// Pattern-side command bus for the FD command collector.
// Carries valid pulses with their shared payload and the assembled command handshake.
`timescale 1ns/1ps
interface fd_cmd_if;
  logic        act_valid;
  logic        id_valid;
  logic        res_valid;
  logic        food_valid;
  logic        cus_valid;
  logic [15:0] D;
  logic        cmd_ready;

  logic        cmd_valid;
  logic [3:0]  cmd_act;
  logic [7:0]  cmd_dman_id;
  logic [7:0]  cmd_res_id;
  logic [1:0]  cmd_food_id;
  logic [3:0]  cmd_ser;
  logic [15:0] cmd_ctm;
  logic        proto_err;

  modport master (
    output act_valid, id_valid, res_valid, food_valid, cus_valid, D, cmd_ready,
    input  cmd_valid, cmd_act, cmd_dman_id, cmd_res_id, cmd_food_id, cmd_ser, cmd_ctm,
    input  proto_err
  );

  modport slave (
    input  act_valid, id_valid, res_valid, food_valid, cus_valid, D, cmd_ready,
    output cmd_valid, cmd_act, cmd_dman_id, cmd_res_id, cmd_food_id, cmd_ser, cmd_ctm,
    output proto_err
  );
endinterface

// File: rtl/fd_cmd_collector.sv
// Collects per-field valid pulses into one complete FD command and holds it until accepted.
// Protocol violations raise a registered one-cycle proto_err pulse.
`timescale 1ns/1ps
module fd_cmd_collector (
  input logic   clk,
  input logic   rst,
  fd_cmd_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle, StTake, StOrder, StDeliver, StCancelR, StCancelF, StCancelI, StHold
  } state_e;

  localparam logic [3:0] ActNone    = 4'd0;
  localparam logic [3:0] ActTake    = 4'd1;
  localparam logic [3:0] ActDeliver = 4'd2;
  localparam logic [3:0] ActOrder   = 4'd4;
  localparam logic [3:0] ActCancel  = 4'd8;

  state_e      state_q, state_d;
  logic [7:0]  dman_q, dman_d;
  logic [7:0]  res_q, res_d;
  logic [3:0]  act_q, act_d;
  logic [1:0]  food_q, food_d;
  logic [3:0]  ser_q, ser_d;
  logic [15:0] ctm_q, ctm_d;
  logic        err_q, err_d;

  logic [2:0]  n_valid;
  logic        any_valid;
  logic        multi_valid;

  assign n_valid = {2'b00, bus.act_valid} + {2'b00, bus.id_valid} + {2'b00, bus.res_valid}
                 + {2'b00, bus.food_valid} + {2'b00, bus.cus_valid};
  assign any_valid   = (n_valid != 3'd0);
  assign multi_valid = (n_valid > 3'd1);

  // Next-state and field-capture decode; exactly one legal pulse advances the command.
  always_comb begin
    state_d = state_q;
    dman_d  = dman_q;
    res_d   = res_q;
    act_d   = act_q;
    food_d  = food_q;
    ser_d   = ser_q;
    ctm_d   = ctm_q;
    err_d   = 1'b0;

    if (multi_valid) begin
      err_d = 1'b1;
      if (state_q != StHold) state_d = StIdle;
    end else if (state_q == StHold) begin
      // A held command is never disturbed by stray pulses.
      if (any_valid) begin
        err_d = 1'b1;
      end else if (bus.cmd_ready) begin
        state_d = StIdle;
      end
    end else if (any_valid) begin
      case (state_q)
        StIdle: begin
          if (bus.act_valid) begin
            case (bus.D[3:0])
              ActTake:    begin act_d = ActTake;    state_d = StTake;    end
              ActDeliver: begin act_d = ActDeliver; state_d = StDeliver; end
              ActOrder:   begin act_d = ActOrder;   state_d = StOrder;   end
              ActCancel:  begin act_d = ActCancel;  state_d = StCancelR; end
              default:    err_d = 1'b1;
            endcase
          end else begin
            err_d = 1'b1;
          end
        end
        StTake: begin
          if (bus.id_valid) begin
            dman_d = bus.D[7:0];
          end else if (bus.cus_valid) begin
            ctm_d   = bus.D;
            state_d = StHold;
          end else begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end
        StDeliver: begin
          if (bus.id_valid) begin
            dman_d  = bus.D[7:0];
            state_d = StHold;
          end else begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end
        StOrder: begin
          if (bus.res_valid) begin
            res_d = bus.D[7:0];
          end else if (bus.food_valid) begin
            food_d  = bus.D[5:4];
            ser_d   = bus.D[3:0];
            state_d = StHold;
          end else begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end
        StCancelR: begin
          if (bus.res_valid) begin
            res_d   = bus.D[7:0];
            state_d = StCancelF;
          end else begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end
        StCancelF: begin
          if (bus.food_valid) begin
            food_d  = bus.D[5:4];
            ser_d   = 4'd0;
            state_d = StCancelI;
          end else begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end
        StCancelI: begin
          if (bus.id_valid) begin
            dman_d  = bus.D[7:0];
            state_d = StHold;
          end else begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and captured fields; reset wipes any partial or held command.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      dman_q  <= 8'd0;
      res_q   <= 8'd0;
      act_q   <= ActNone;
      food_q  <= 2'd0;
      ser_q   <= 4'd0;
      ctm_q   <= 16'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dman_q  <= dman_d;
      res_q   <= res_d;
      act_q   <= act_d;
      food_q  <= food_d;
      ser_q   <= ser_d;
      ctm_q   <= ctm_d;
      err_q   <= err_d;
    end
  end

  assign bus.cmd_valid   = (state_q == StHold);
  assign bus.cmd_act     = act_q;
  assign bus.cmd_dman_id = dman_q;
  assign bus.cmd_res_id  = res_q;
  assign bus.cmd_food_id = food_q;
  assign bus.cmd_ser     = ser_q;
  assign bus.cmd_ctm     = ctm_q;
  assign bus.proto_err   = err_q;

endmodule

// File: tb/tb_fd_cmd_collector.sv
// Scoreboard bench for fd_cmd_collector: transaction-level model predicts each command.
`timescale 1ns/1ps
module tb_fd_cmd_collector;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fd_cmd_if bus();

  fd_cmd_collector dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  localparam logic [4:0] MA = 5'b10000;
  localparam logic [4:0] MI = 5'b01000;
  localparam logic [4:0] MR = 5'b00100;
  localparam logic [4:0] MF = 5'b00010;
  localparam logic [4:0] MC = 5'b00001;

  typedef struct packed {
    logic [3:0]  act;
    logic [7:0]  dman;
    logic [7:0]  res;
    logic [1:0]  food;
    logic [3:0]  ser;
    logic [15:0] ctm;
  } cmd_t;

  cmd_t exp_q[$];

  // Reference model: the fields a completed command will present.
  logic [7:0]  last_dman = 8'd0;
  logic [7:0]  last_res  = 8'd0;
  logic [3:0]  m_act     = 4'd0;
  logic [1:0]  m_food    = 2'd0;
  logic [3:0]  m_ser     = 4'd0;
  logic [15:0] m_ctm     = 16'd0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic cmd_t cur_cmd();
    cmd_t c;
    c = '{act: bus.cmd_act, dman: bus.cmd_dman_id, res: bus.cmd_res_id,
          food: bus.cmd_food_id, ser: bus.cmd_ser, ctm: bus.cmd_ctm};
    return c;
  endfunction

  task automatic push_exp();
    cmd_t c;
    c = '{act: m_act, dman: last_dman, res: last_res, food: m_food, ser: m_ser, ctm: m_ctm};
    exp_q.push_back(c);
  endtask

  // Monitor: pops an expectation on each new command and checks it stays stable while held.
  initial begin
    logic prev_valid;
    cmd_t held;
    cmd_t e;
    prev_valid = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0;
      end else begin
        if (bus.cmd_valid && !prev_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_cmd_valid", 64'(bus.cmd_valid), 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("cmd_act",     64'(bus.cmd_act),     64'(e.act));
            check("cmd_dman_id", 64'(bus.cmd_dman_id), 64'(e.dman));
            check("cmd_res_id",  64'(bus.cmd_res_id),  64'(e.res));
            check("cmd_food_id", 64'(bus.cmd_food_id), 64'(e.food));
            check("cmd_ser",     64'(bus.cmd_ser),     64'(e.ser));
            check("cmd_ctm",     64'(bus.cmd_ctm),     64'(e.ctm));
          end
          held = cur_cmd();
        end else if (bus.cmd_valid && prev_valid) begin
          check("hold_stable", 64'(cur_cmd()), 64'(held));
        end
        prev_valid = bus.cmd_valid;
      end
    end
  end

  // One clock of stimulus; pulses in mask m are sampled at the next rising edge.
  task automatic drive(input logic [4:0] m, input logic [15:0] d, input bit exp_err,
                       input string nm);
    {bus.act_valid, bus.id_valid, bus.res_valid, bus.food_valid, bus.cus_valid} = m;
    bus.D = d;
    @(posedge clk);
    #1;
    {bus.act_valid, bus.id_valid, bus.res_valid, bus.food_valid, bus.cus_valid} = 5'b0;
    bus.D = 16'($urandom);
    check(nm, 64'(bus.proto_err), 64'(exp_err));
  endtask

  // Quiet cycles mid-command; cmd_ready toggles randomly and must be ignored.
  task automatic gap();
    int n;
    n = $urandom_range(2, 0);
    for (int i = 0; i < n; i++) begin
      bus.cmd_ready = 1'($urandom_range(1, 0));
      drive(5'b0, 16'($urandom), 1'b0, "gap_quiet");
      bus.cmd_ready = 1'b0;
    end
  endtask

  // Holds the completed command n cycles with cmd_ready low, then releases it.
  // inj: -1 random stray pulses, -2 none, otherwise the cycle index for mask inj_m.
  task automatic hold(input int n, input int inj, input logic [4:0] inj_m);
    logic [4:0] m;
    for (int i = 0; i < n; i++) begin
      if (i == inj) begin
        drive(inj_m, 16'($urandom), 1'b1, "hold_err");
      end else if (inj == -1 && $urandom_range(3, 0) == 0) begin
        m = 5'b00001 << $urandom_range(4, 0);
        drive(m, 16'($urandom), 1'b1, "hold_err");
      end else begin
        drive(5'b0, 16'($urandom), 1'b0, "hold_quiet");
      end
    end
    check("held_valid", 64'(bus.cmd_valid), 64'd1);
    bus.cmd_ready = 1'b1;
    drive(5'b0, 16'($urandom), 1'b0, "release");
    bus.cmd_ready = 1'b0;
    check("release_drop", 64'(bus.cmd_valid), 64'd0);
  endtask

  task automatic cmd_take(input bit with_id, input logic [7:0] id, input logic [15:0] ctm,
                          input int hn, input int inj);
    drive(MA, {12'($urandom), 4'd1}, 1'b0, "take_act");
    m_act = 4'd1;
    gap();
    if (with_id) begin
      drive(MI, {8'($urandom), id}, 1'b0, "take_id");
      last_dman = id;
      gap();
    end
    drive(MC, ctm, 1'b0, "take_cus");
    m_ctm = ctm;
    push_exp();
    hold(hn, inj, MA);
  endtask

  task automatic cmd_deliver(input logic [7:0] id, input int hn, input int inj);
    drive(MA, {12'($urandom), 4'd2}, 1'b0, "deliver_act");
    m_act = 4'd2;
    gap();
    drive(MI, {8'($urandom), id}, 1'b0, "deliver_id");
    last_dman = id;
    push_exp();
    hold(hn, inj, MA);
  endtask

  task automatic cmd_order(input bit with_res, input logic [7:0] res, input logic [1:0] food,
                           input logic [3:0] ser, input int hn, input int inj,
                           input logic [4:0] inj_m);
    drive(MA, {12'($urandom), 4'd4}, 1'b0, "order_act");
    m_act = 4'd4;
    gap();
    if (with_res) begin
      drive(MR, {8'($urandom), res}, 1'b0, "order_res");
      last_res = res;
      gap();
    end
    drive(MF, {10'($urandom), food, ser}, 1'b0, "order_food");
    m_food = food;
    m_ser  = ser;
    push_exp();
    hold(hn, inj, inj_m);
  endtask

  task automatic cmd_cancel(input logic [7:0] res, input logic [1:0] food, input logic [7:0] id,
                            input int hn, input int inj);
    drive(MA, {12'($urandom), 4'd8}, 1'b0, "cancel_act");
    m_act = 4'd8;
    gap();
    drive(MR, {8'($urandom), res}, 1'b0, "cancel_res");
    last_res = res;
    gap();
    drive(MF, {10'($urandom), food, 4'($urandom)}, 1'b0, "cancel_food");
    m_food = food;
    m_ser  = 4'd0;
    gap();
    drive(MI, {8'($urandom), id}, 1'b0, "cancel_id");
    last_dman = id;
    push_exp();
    hold(hn, inj, MA);
  endtask

  task automatic bad_act(input logic [3:0] code);
    drive(MA, {12'($urandom), code}, 1'b1, "bad_act_err");
  endtask

  // Illegal pulse after a partial command: command dropped, earlier fields untouched.
  task automatic abort_cmd(input int which);
    case (which)
      0: begin
        drive(MA, {12'($urandom), 4'd2}, 1'b0, "abort_act");
        m_act = 4'd2;
        gap();
        drive(MR, 16'($urandom), 1'b1, "abort_deliver_res");
      end
      1: begin
        drive(MA, {12'($urandom), 4'd1}, 1'b0, "abort_act");
        m_act = 4'd1;
        gap();
        drive(MA, {12'($urandom), 4'd1}, 1'b1, "abort_take_act");
      end
      default: begin
        drive(MA, {12'($urandom), 4'd4}, 1'b0, "abort_act");
        m_act = 4'd4;
        gap();
        drive(MI, 16'($urandom), 1'b1, "abort_order_id");
      end
    endcase
  endtask

  task automatic double_valid();
    drive(MA, {12'($urandom), 4'd1}, 1'b0, "double_act");
    m_act = 4'd1;
    drive(MI | MR, 16'($urandom), 1'b1, "double_err");
  endtask

  task automatic check_reset_outputs();
    check("rst_cmd_valid", 64'(bus.cmd_valid),   64'd0);
    check("rst_proto_err", 64'(bus.proto_err),   64'd0);
    check("rst_cmd_act",   64'(bus.cmd_act),     64'd0);
    check("rst_dman",      64'(bus.cmd_dman_id), 64'd0);
    check("rst_res",       64'(bus.cmd_res_id),  64'd0);
    check("rst_food",      64'(bus.cmd_food_id), 64'd0);
    check("rst_ser",       64'(bus.cmd_ser),     64'd0);
    check("rst_ctm",       64'(bus.cmd_ctm),     64'd0);
  endtask

  task automatic model_reset();
    last_dman = 8'd0;
    last_res  = 8'd0;
    m_act     = 4'd0;
    m_food    = 2'd0;
    m_ser     = 4'd0;
    m_ctm     = 16'd0;
  endtask

  // Reset while an Order is half built, with a food pulse in the same cycle.
  task automatic reset_mid_order(input logic [7:0] r);
    drive(MA, {12'($urandom), 4'd4}, 1'b0, "rstord_act");
    drive(MR, {8'($urandom), r}, 1'b0, "rstord_res");
    bus.food_valid = 1'b1;
    bus.D = 16'h0023;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.food_valid = 1'b0;
    model_reset();
    check_reset_outputs();
  endtask

  initial begin
    int kind;
    rst = 1'b1;
    {bus.act_valid, bus.id_valid, bus.res_valid, bus.food_valid, bus.cus_valid} = 5'b0;
    bus.D = 16'd0;
    bus.cmd_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_outputs();

    cmd_take(1'b1, 8'h05, 16'h04A3, 2, -2);
    cmd_take(1'b0, 8'h00, 16'hC123, 1, -2);
    cmd_cancel(8'h21, 2'b10, 8'h07, 0, -2);
    cmd_order(1'b1, 8'h44, 2'd1, 4'd3, 10, 5, MA);
    bad_act(4'd3);
    abort_cmd(0);
    double_valid();
    cmd_deliver(8'h9C, 1, -2);
    reset_mid_order(8'h33);
    cmd_order(1'b0, 8'h00, 2'd3, 4'd9, 0, -2, MA);

    for (int t = 0; t < 300; t++) begin
      kind = $urandom_range(9, 0);
      case (kind)
        0, 1: cmd_take(1'($urandom), 8'($urandom), 16'($urandom), $urandom_range(3, 0), -1);
        2:    cmd_deliver(8'($urandom), $urandom_range(3, 0), -1);
        3, 4: cmd_order(1'($urandom), 8'($urandom), 2'($urandom), 4'($urandom),
                        $urandom_range(3, 0), -1, MA);
        5:    cmd_cancel(8'($urandom), 2'($urandom), 8'($urandom), $urandom_range(3, 0), -1);
        6:    bad_act(4'($urandom_range(15, 9)));
        7:    abort_cmd($urandom_range(2, 0));
        8:    double_valid();
        default: reset_mid_order(8'($urandom));
      endcase
      gap();
    end

    repeat (3) drive(5'b0, 16'($urandom), 1'b0, "tail_quiet");
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
